// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the connection-block configuration path: vector sizing and loader states.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StReadback
    } cfg_state_e;

    function automatic int unsigned calc_cfg_w(
        input int unsigned ws,
        input int unsigned wd,
        input int unsigned wg,
        input int unsigned clbin0,
        input int unsigned clbin1,
        input int unsigned clbout0,
        input int unsigned clbout1,
        input int unsigned clbos,
        input int unsigned clbod,
        input int unsigned clbx
    );
        return clbout0 * (clbos + clbod) + clbin0 * (ws + wd + wg + clbx * clbout1)
             + clbout1 * (clbos + clbod) + clbin1 * (ws + wd + wg + clbx * clbout0);
    endfunction

    function automatic int unsigned calc_nw(input int unsigned cfg_w, input int unsigned data_w);
        return (cfg_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/cfg_word_shifter.sv
// Shadow configuration register with indexed word write, plus an indexed word read mux
// over an arbitrary source vector (used to read back the active configuration).
module cfg_word_shifter
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned CFG_W = 88,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned NW = calc_nw(CFG_W, DATA_W),
    localparam int unsigned IDX_W = $clog2(NW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CFG_W-1:0]  shadow_nxt,
    input  logic [CFG_W-1:0]  rd_src,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned POS_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic [CFG_W-1:0] shadow_q;

    // Bits that fall past CFG_W in the final word are dropped on write and read as zero.
    always_comb begin
        int unsigned wpos;
        wpos = 0;
        shadow_nxt = shadow_q;
        if (wr_en) begin
            for (int b = 0; b < DATA_W; b++) begin
                wpos = 32'(wr_idx) * DATA_W + 32'(b);
                if (wpos < CFG_W) begin
                    shadow_nxt[POS_W'(wpos)] = wr_data[b];
                end
            end
        end
    end

    always_comb begin
        int unsigned rpos;
        rpos = 0;
        rd_data = '0;
        for (int b = 0; b < DATA_W; b++) begin
            rpos = 32'(rd_idx) * DATA_W + 32'(b);
            if (rpos < CFG_W) begin
                rd_data[b] = rd_src[POS_W'(rpos)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (clr) begin
            shadow_q <= '0;
        end else if (wr_en) begin
            shadow_q <= shadow_nxt;
        end
    end

endmodule

// File: rtl/cb_config_loader.sv
// Word-serial configuration loader for connection_block: assembles frames in a shadow
// register, commits them atomically to c, and streams the active vector back on request.
module cb_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned WS = 7,
    parameter int unsigned WD = 6,
    parameter int unsigned WG = 3,
    parameter int unsigned CLBIN0 = 2,
    parameter int unsigned CLBIN1 = 2,
    parameter int unsigned CLBOUT0 = 2,
    parameter int unsigned CLBOUT1 = 2,
    parameter int unsigned CLBOS = 2,
    parameter int unsigned CLBOD = 2,
    parameter int unsigned CLBX = 1,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CFG_W = calc_cfg_w(WS, WD, WG, CLBIN0, CLBIN1, CLBOUT0, CLBOUT1,
                                               CLBOS, CLBOD, CLBX),
    localparam int unsigned NW = calc_nw(CFG_W, DATA_W),
    localparam int unsigned CNT_W = $clog2(NW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_in_valid,
    output logic              cfg_in_ready,
    input  logic [DATA_W-1:0] cfg_in_data,
    input  logic              cfg_in_last,
    input  logic              rb_req,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_last,
    output logic [CFG_W-1:0]  c,
    output logic              cfg_valid,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NW - 1);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  wr_idx;
    logic [CFG_W-1:0]  c_q;
    logic [CFG_W-1:0]  shadow_nxt;
    logic [DATA_W-1:0] rd_word;
    logic              cfg_valid_q, done_q, err_q;
    logic              accept, wr_en, clr, commit, frame_err;

    // Reset asserts asynchronously but is released to the logic on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cfg_in_ready = 1'b0;
        wr_idx       = cnt_q;
        accept       = 1'b0;
        wr_en        = 1'b0;
        clr          = 1'b0;
        commit       = 1'b0;
        frame_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cfg_in_ready = rst_int_n & ~rb_req;
                wr_idx       = '0;
                if (rb_req) begin
                    state_d = StReadback;
                    cnt_d   = '0;
                end else if (cfg_in_valid && rst_int_n) begin
                    accept = 1'b1;
                end
            end
            StLoad: begin
                cfg_in_ready = 1'b1;
                accept       = cfg_in_valid;
            end
            StDrain: begin
                cfg_in_ready = 1'b1;
                if (cfg_in_valid && cfg_in_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StReadback: begin
                if (rb_ready) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared word-acceptance path for the first word (IDLE) and later words (LOAD).
        if (accept) begin
            wr_en = 1'b1;
            cnt_d = wr_idx + CNT_W'(1);
            if (wr_idx == LastIdx) begin
                if (cfg_in_last) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    frame_err = 1'b1;
                    clr       = 1'b1;
                    state_d   = StDrain;
                end
            end else if (cfg_in_last) begin
                frame_err = 1'b1;
                clr       = 1'b1;
                state_d   = StIdle;
                cnt_d     = '0;
            end else begin
                state_d = StLoad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            c_q         <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
            err_q   <= frame_err;
            if (commit) begin
                c_q         <= shadow_nxt;
                cfg_valid_q <= 1'b1;
            end
        end
    end

    cfg_word_shifter #(
        .CFG_W  (CFG_W),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (cfg_in_data),
        .shadow_nxt (shadow_nxt),
        .rd_src     (c_q),
        .rd_idx     (cnt_q),
        .rd_data    (rd_word)
    );

    assign rb_valid  = (state_q == StReadback);
    assign rb_data   = rb_valid ? rd_word : '0;
    assign rb_last   = rb_valid && (cnt_q == LastIdx);
    assign c         = c_q;
    assign cfg_valid = cfg_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader at default parameters (88-bit vector, 11 byte words).
module tb_cb_config_loader;

    localparam int CFG_W = 88;
    localparam int DATA_W = 8;

    localparam logic [87:0] EXP_A = 88'h0B_0A_09_08_07_06_05_04_03_02_01;
    localparam logic [87:0] EXP_B = 88'h1A_19_18_17_16_15_14_13_12_11_55;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_in_valid = 1'b0;
    logic              cfg_in_ready;
    logic [DATA_W-1:0] cfg_in_data = '0;
    logic              cfg_in_last = 1'b0;
    logic              rb_req = 1'b0;
    logic              rb_valid;
    logic              rb_ready = 1'b0;
    logic [DATA_W-1:0] rb_data;
    logic              rb_last;
    logic [CFG_W-1:0]  c;
    logic              cfg_valid;
    logic              done;
    logic              err;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    cb_config_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_in_valid (cfg_in_valid),
        .cfg_in_ready (cfg_in_ready),
        .cfg_in_data  (cfg_in_data),
        .cfg_in_last  (cfg_in_last),
        .rb_req       (rb_req),
        .rb_valid     (rb_valid),
        .rb_ready     (rb_ready),
        .rb_data      (rb_data),
        .rb_last      (rb_last),
        .c            (c),
        .cfg_valid    (cfg_valid),
        .done         (done),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was transferred.
    task automatic send_word(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        cfg_in_valid = 1'b1;
        cfg_in_data  = d;
        cfg_in_last  = l;
        while (1) begin
            #1;
            if (cfg_in_ready) break;
            n++;
            if (n > 50) begin
                check("ready_timeout", 88'(cfg_in_ready), 88'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        cfg_in_last  = 1'b0;
    endtask

    task automatic drain_readback(input int toggle, input logic [87:0] exp);
        int beats;
        int cyc;
        logic [7:0] held;
        logic stalled;
        beats   = 0;
        cyc     = 0;
        held    = '0;
        stalled = 1'b0;
        while (beats < 11 && cyc < 60) begin
            rb_ready = (toggle == 0) ? 1'b1 : ((cyc % 2) == 0);
            #1;
            if (stalled) check("rb_stall_data", 88'(rb_data), 88'(held));
            stalled = 1'b0;
            check("rb_in_ready_low", 88'(cfg_in_ready), 88'd0);
            if (!rb_valid) begin
                check("rb_valid", 88'(rb_valid), 88'd1);
            end else if (rb_ready) begin
                check("rb_data", 88'(rb_data), 88'(exp[beats*8 +: 8]));
                check("rb_last", 88'(rb_last), 88'(beats == 10));
                beats++;
            end else begin
                held    = rb_data;
                stalled = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        rb_ready = 1'b0;
        check("rb_beats", 88'(beats), 88'd11);
        #1;
        check("rb_valid_end", 88'(rb_valid), 88'd0);
        check("rb_busy_end", 88'(busy), 88'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("reset_c", c, 88'd0);
        check("reset_cfg_valid", 88'(cfg_valid), 88'd0);
        check("reset_busy", 88'(busy), 88'd0);
        check("reset_done_err", 88'({done, err}), 88'd0);
        check("reset_rb", 88'({rb_valid, rb_last, rb_data}), 88'd0);
        check("reset_ready", 88'(cfg_in_ready), 88'd1);
        @(negedge clk);

        // Full 11-word frame.
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 1; i <= 11; i++) send_word(8'(i), i == 11);
        check("load_done", 88'(done), 88'd1);
        check("load_c", c, EXP_A);
        check("load_cfg_valid", 88'(cfg_valid), 88'd1);
        repeat (2) @(negedge clk);
        check("load_done_once", 88'(done_cnt), 88'd1);
        check("load_no_err", 88'(err_cnt), 88'd0);
        check("load_done_clear", 88'(done), 88'd0);

        // Early last on word 5.
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 1; i <= 5; i++) send_word(8'(8'hA0 + i), i == 5);
        check("early_err", 88'(err), 88'd1);
        check("early_c", c, EXP_A);
        check("early_cfg_valid", 88'(cfg_valid), 88'd1);
        check("early_idle", 88'(busy), 88'd0);
        repeat (2) @(negedge clk);
        check("early_err_once", 88'(err_cnt), 88'd1);
        check("early_no_done", 88'(done_cnt), 88'd0);

        // 14-word frame: overflow error after word 11, remainder drained.
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 1; i <= 14; i++) begin
            send_word(8'(8'hC0 + i), i == 14);
            if (i == 11) begin
                check("long_err", 88'(err), 88'd1);
                check("long_drain_busy", 88'(busy), 88'd1);
            end
        end
        #1;
        check("long_idle", 88'(busy), 88'd0);
        check("long_c", c, EXP_A);
        repeat (2) @(negedge clk);
        check("long_err_once", 88'(err_cnt), 88'd1);
        check("long_no_done", 88'(done_cnt), 88'd0);

        // Readback with rb_ready toggling.
        rb_req = 1'b1;
        @(negedge clk);
        rb_req = 1'b0;
        drain_readback(1, EXP_A);
        @(negedge clk);

        // rb_req and a waiting input word in the same idle cycle.
        rb_req       = 1'b1;
        cfg_in_valid = 1'b1;
        cfg_in_data  = 8'h55;
        cfg_in_last  = 1'b0;
        #1;
        check("collide_ready", 88'(cfg_in_ready), 88'd0);
        @(negedge clk);
        rb_req = 1'b0;
        drain_readback(0, EXP_A);
        done_cnt = 0;
        send_word(8'h55, 1'b0);
        for (int k = 1; k <= 10; k++) send_word(8'(8'h10 + k), k == 10);
        check("collide_done", 88'(done), 88'd1);
        check("collide_c", c, EXP_B);

        // Reset during word 6 of a load.
        for (int i = 1; i <= 5; i++) send_word(8'(8'h20 + i), 1'b0);
        cfg_in_valid = 1'b1;
        cfg_in_data  = 8'h26;
        rst_n        = 1'b0;
        #1;
        check("midrst_c", c, 88'd0);
        check("midrst_cfg_valid", 88'(cfg_valid), 88'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        cfg_in_valid = 1'b0;
        #1;
        check("midrst_idle", 88'(busy), 88'd0);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 11; i++) send_word(8'(i), i == 11);
        check("reload_done", 88'(done), 88'd1);
        check("reload_c", c, EXP_A);
        check("reload_cfg_valid", 88'(cfg_valid), 88'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cb_config_loader.md
Name: cb_config_loader

Overview:
- Writer side of the connection block's configuration vector `c`.
- Accepts a word-serial configuration bitstream over a valid/ready stream and assembles it in a shadow register.
- Commits the assembled vector atomically to the `c` output driving `connection_block`, so the routing fabric never sees a partial configuration.
- Supports readback of the active configuration over a second valid/ready stream.

Parameters:
- WS, 7, single-wire tracks
- WD, 6, double-wire tracks
- WG, 3, global lines
- CLBIN0 / CLBIN1, 2 / 2, CLB inputs, side 0 / side 1
- CLBOUT0 / CLBOUT1, 2 / 2, CLB outputs, side 0 / side 1
- CLBOS / CLBOD, 2 / 2, single/double taps per CLB output
- CLBX, 1, cross-CLB input connections enabled
- CFG_W, derived; not overridable:
  - formula: CLBOUT0*(CLBOS+CLBOD) + CLBIN0*(WS+WD+WG+CLBX*CLBOUT1) + CLBOUT1*(CLBOS+CLBOD) + CLBIN1*(WS+WD+WG+CLBX*CLBOUT0)
  - value: 88 at defaults
- DATA_W, 8, stream word width
- NW, derived, ceil(CFG_W/DATA_W); 11 at defaults

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_in_valid  in  1  input word valid
- cfg_in_ready  out  1  loader accepts word
- cfg_in_data  in  DATA_W  configuration word
- cfg_in_last  in  1  final word of frame
- rb_req  in  1  single-cycle readback request
- rb_valid  out  1  readback word valid
- rb_ready  in  1  readback consumer ready
- rb_data  out  DATA_W  readback word
- rb_last  out  1  final readback word
- c  out  CFG_W  active configuration vector to connection_block
- cfg_valid  out  1  `c` holds a committed frame
- done  out  1  one-cycle pulse on commit
- err  out  1  one-cycle pulse on malformed frame
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync deassert internally) drives: state=IDLE, c=0, shadow=0, cfg_valid=0, done=0, err=0, rb_valid=0, rb_last=0, rb_data=0, word counter=0.
- Reset mid-load or mid-readback abandons the operation; `c` returns to 0.
- Bit mapping: word k carries c[k*DATA_W +: DATA_W], LSB first. Pad bits beyond CFG_W in word NW-1 are ignored on load and read back as 0.
- Handshake: a transfer occurs when valid && ready on a rising edge. Data and valid are held stable until ready, on both streams.
- States: IDLE, LOAD, DRAIN, READBACK.
- IDLE:
  - cfg_in_ready=1 unless rb_req=1; rb_req has priority on a same-cycle collision.
  - rb_req -> READBACK, counter=0.
  - Accepted word: write shadow word 0, counter=1, -> LOAD.
  - If NW==1 and last: commit directly.
- LOAD:
  - cfg_in_ready=1; rb_req ignored.
  - Accepted word at index k: write shadow word k, counter=k+1.
  - last && k==NW-1: commit. Shadow copies to `c` on the same edge (visible next cycle), cfg_valid=1, done pulses, -> IDLE.
  - last && k<NW-1: err pulses, shadow discarded, `c` unchanged, -> IDLE.
  - !last && k==NW-1: err pulses, -> DRAIN.
- DRAIN:
  - cfg_in_ready=1; words discarded.
  - Accepted last word -> IDLE.
  - `c` unchanged throughout.
- READBACK:
  - cfg_in_ready=0.
  - rb_valid=1 with rb_data = active c word[counter]; rb_last = (counter==NW-1).
  - On transfer: counter++. On the last transfer -> IDLE, rb_valid=0 the next cycle.
  - rb_ready held low stalls indefinitely with outputs stable.
- `c` changes only on a commit edge or on reset. Never partial.
- done and err are mutually exclusive.
- Counter width: $clog2(NW+1).
- No combinational path from cfg_in_data to `c`.

Decomposition:
- Shared package `fabric_cfg_pkg`:
  - CFG_W and NW computation functions, reused by connection_block and benches
  - state enum
- One natural sub-module, `cfg_word_shifter`: shadow register with indexed word write and indexed word read mux, parameterised by CFG_W and DATA_W.
- FSM, counter, and commit logic stay in the top module.

Test Plan:
- Load 11 words 0x01..0x0B with last on word 11:
  - done pulses once
  - c == {0x0B[7:0] truncated to 0x0B, ..., 0x02, 0x01} with bits 88+ dropped
  - cfg_valid=1
- Early last on word 5:
  - err pulses
  - c retains previous value 0x...0B0A..01
  - cfg_valid unchanged
- 14-word frame, last on word 14:
  - err pulses after word 11
  - words 12–14 accepted and discarded
  - c unchanged; state IDLE after word 14
- Readback after a valid load, rb_ready toggling 1,0,1 pattern:
  - exactly 11 beats matching loaded words
  - rb_last on beat 11 only
  - data stable during stalls
- rb_req and cfg_in_valid asserted in the same IDLE cycle:
  - readback starts; cfg_in_ready=0
  - input word not consumed; load proceeds after readback
- rst_n low for 1 cycle during word 6 of a load:
  - c=0, cfg_valid=0, state IDLE
  - a fresh 11-word load then commits correctly
